tmds_encoder: RTL
=================

// Module: tmds_encoder
// PURPOSE
//  Single-channel DVI/HDMI TMDS 8b/10b encoder with running DC balance. Sits directly downstream
//  of the sync/timing generator: takes its de and vh (hsync/vsync) plus 8-bit pixel data, and
//  emits 10-bit symbols for the serializer. Instantiated three times (B/G/R). Blue gets c = vh;
//  green and red get c = 2'b00.
// PARAMETERS
//  PIPELINED   1   1: two register stages, latency 2 (stage1 = qm/n1 calc, stage2 = DC balance); 0: latency 1
// PORTS
//  clk      in   1    pixel clock; the only clock
//  rst      in   1    reset, synchronous, active-high
//  de       in   1    data enable: 1 = encode d, 0 = send control symbol for c
//  c        in   2    control bits. c[0] = hsync, c[1] = vsync (same order as the sync block's vh)
//  d        in   8    pixel component
//  q        out  10   TMDS symbol; LSB transmitted first
// BEHAVIOUR
//  Reset
//   - rst = 1 at a clk edge: q <= 10'h354 (control code for c = 00), disparity cnt <= 0.
//   - All pipeline stages load de = 0, c = 00. The first PIPELINED+1 symbols after release are 10'h354.
//  Latency
//   - q at edge N+1+PIPELINED reflects de/c/d sampled at edge N.
//   - de, c and d travel together through every stage; no cross-cycle mixing.
//  Stage 1: transition minimise
//   - n1d = popcount(d).
//   - XNOR mode if n1d > 4, or if (n1d == 4 && d[0] == 0). Otherwise XOR mode.
//   - qm[0] = d[0]; qm[i] = qm[i-1] ^ d[i] (XOR) or ~(qm[i-1] ^ d[i]) (XNOR), for i = 1..7.
//   - qm[8] = 1 for XOR, 0 for XNOR.
//  Stage 2: DC balance
//   - n1 = popcount(qm[7:0]), n0 = 8 - n1. cnt is a 6-bit signed register.
//   - Case A, cnt == 0 or n1 == n0:
//     q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
//     cnt += qm[8] ? (n1 - n0) : (n0 - n1).
//   - Case B, (cnt > 0 && n1 > n0) or (cnt < 0 && n0 > n1):
//     q = {1, qm[8], ~qm[7:0]};
//     cnt += 2*qm[8] + (n0 - n1).
//   - Case C, otherwise:
//     q = {0, qm[8], qm[7:0]};
//     cnt += -2*(~qm[8]) + (n1 - n0).
//   - All arithmetic is signed and at least 6 bits wide.
//   - cnt must stay within -10..+10 and even; never wraps.
//  Control period (de = 0 at stage 2)
//   - q by c: 00 -> 10'h354, 01 -> 10'h0AB, 10 -> 10'h154, 11 -> 10'h2AB. cnt <= 0.
//   - d is ignored in this period (don't-care).
//  Boundaries
//   - de 0 -> 1: the first data symbol uses cnt = 0.
//   - de toggling every cycle: each symbol is encoded independently per the rules above.
//   - rst mid-line: no partial symbol is emitted; the next q is 10'h354.
// TESTING
//  1. rst held 3 cycles, de = 0, c = 00 -> q = 10'h354 every cycle; then c = 11 -> q = 10'h2AB after latency.
//  2. cnt = 0, de = 1, d = 8'h00 twice:
//     - first symbol q = 10'h100, cnt = -8;
//     - second symbol q = 10'h3FF, cnt = +2.
//  3. cnt = 0, de = 1, d = 8'hFF -> q = 10'h200, cnt = -8.
//  4. Latency check: d = 8'h00, 8'h01, ... 8'hFF back-to-back with de = 1, for PIPELINED = 0 and 1.
//     - q must match a behavioural reference model symbol-for-symbol at latency 1 / 2.
//     - |cnt| <= 10 throughout.
//  5. Full 800x525 frame from the sync block with random pixels; decode q with a reference decoder.
//     - Pixels recovered exactly; hsync/vsync recovered from control codes on the blue lane.
//     - Running disparity at the end of each active line stays within ±10.
//  6. Assert rst in the middle of an active line (cnt != 0) -> next q = 10'h354 and cnt = 0.
//     After release: de = 1, d = 8'h00 -> q = 10'h100.

Source files
------------

// File: rtl/tmds_encoder.sv
// tmds_encoder: single-channel DVI/HDMI TMDS 8b/10b encoder with running DC balance.
module tmds_encoder #(
    parameter bit PIPELINED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de,
    input  logic [1:0] c,
    input  logic [7:0] d,
    output logic [9:0] q
);
    logic [3:0]        n1d, n1_c, n1_s;
    logic              xnor_mode;
    logic [8:0]        qm_c, qm_s;
    logic              de_s;
    logic [1:0]        c_s;
    logic signed [5:0] cnt, cnt_n, diff;
    logic [9:0]        q_c, ctl;
    logic              case_a, case_b;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) n1d += {3'b0, d[i]};
        xnor_mode = n1d > 4'd4 || (n1d == 4'd4 && !d[0]);
    end

    // The XNOR chain equals the XOR prefix with every odd bit inverted.
    for (genvar g = 0; g < 8; g++) begin : g_qm
        assign qm_c[g] = (^d[g:0]) ^ (xnor_mode & (g % 2 == 1));
    end
    assign qm_c[8] = !xnor_mode;

    always_comb begin
        n1_c = '0;
        for (int i = 0; i < 8; i++) n1_c += {3'b0, qm_c[i]};
    end

    if (PIPELINED) begin : g_pipe
        always_ff @(posedge clk) begin
            if (rst) begin
                de_s <= 1'b0;
                c_s  <= 2'b00;
                qm_s <= '0;
                n1_s <= '0;
            end else begin
                de_s <= de;
                c_s  <= c;
                qm_s <= qm_c;
                n1_s <= n1_c;
            end
        end
    end else begin : g_comb
        always_comb begin
            de_s = de;
            c_s  = c;
            qm_s = qm_c;
            n1_s = n1_c;
        end
    end

    always_comb begin
        diff   = $signed({1'b0, n1_s, 1'b0}) - 6'sd8;
        case_a = cnt == 6'sd0 || n1_s == 4'd4;
        case_b = (cnt > 6'sd0 && n1_s > 4'd4) || (cnt < 6'sd0 && n1_s < 4'd4);
        ctl    = c_s == 2'b00 ? 10'h354 : c_s == 2'b01 ? 10'h0AB : c_s == 2'b10 ? 10'h154 : 10'h2AB;
        q_c    = case_a ? {~qm_s[8], qm_s[8], qm_s[8] ? qm_s[7:0] : ~qm_s[7:0]} :
                 case_b ? {1'b1, qm_s[8], ~qm_s[7:0]} : {1'b0, qm_s[8], qm_s[7:0]};
        cnt_n  = case_a ? cnt + (qm_s[8] ? diff : -diff) :
                 case_b ? cnt + (qm_s[8] ? 6'sd2 : 6'sd0) - diff :
                          cnt - (qm_s[8] ? 6'sd0 : 6'sd2) + diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= 10'h354;
            cnt <= '0;
        end else if (!de_s) begin
            q   <= ctl;
            cnt <= '0;
        end else begin
            q   <= q_c;
            cnt <= cnt_n;
        end
    end
endmodule
